arb_mem_responder: RTL
======================

Name: arb_mem_responder

Overview:
- Target-side memory model for the engine arbiter port (arb_req/arb_we/arb_addr/arb_wdata → arb_valid/arb_rdata).
- Serves the DMA loads and stores issued by one NTT engine core from an internal 64-bit word array.
- Read latency is fixed and pipelined, and responses return in order, so the engine's back-to-back 4096-word bursts are served at one word per cycle.
- Used as the host/HBM stand-in for single-core simulation and bring-up.

Parameters:
- MEM_WORDS_LOG, 13: log2 of the number of 64-bit words in the array (default 8192 words).
- BASE_ADDR, 48'h0: byte address that maps to word 0.
- READ_LAT, 4: cycles from read acceptance to arb_valid. Legal range 1..16.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- arb_req  in  1  request strobe. Every high cycle is one request; the port has no backpressure.
- arb_we  in  1  1 = write, 0 = read.
- arb_addr  in  48  byte address.
- arb_wdata  in  64  write data.
- arb_valid  out  1  one-cycle read-response strobe.
- arb_rdata  out  64  read-response data.
- clr_stats  in  1  synchronous clear of the statistics and err_flag.
- err_flag  out  1  sticky; set on any address error.
- rd_cnt  out  32  count of accepted reads.
- wr_cnt  out  32  count of accepted writes.
- err_cnt  out  16  count of address errors.

Behaviour:
- Reset is asynchronous and active-high. Reset values: arb_valid=0, arb_rdata=0, err_flag=0, all counters 0. The latency pipeline is flushed. The memory array is not reset and keeps its contents.
- Reset asserted mid-burst: every in-flight read is discarded. No arb_valid is produced for those reads, either during reset or after it is released.
- Every request is accepted in the cycle it is presented.
- Address decode: off = arb_addr - BASE_ADDR; index = off[MEM_WORDS_LOG+2:3].
- A request is in range only when all three hold: arb_addr >= BASE_ADDR; off < 8 × 2^MEM_WORDS_LOG; arb_addr[2:0] == 0. Anything else is an address error.
- Write, in range: mem[index] <= arb_wdata at the accepting edge. No arb_valid is generated.
- Write, address error: the write is dropped and counted as an error. No response.
- Read, in range: the array is sampled in the accept cycle, so the read sees every write accepted in earlier cycles. Data enters a READ_LAT-deep valid/data shift pipeline.
- Read accepted at edge t: arb_valid=1 for exactly the cycle following edge t+READ_LAT-1, i.e. READ_LAT cycles after acceptance.
- Read, address error: still produces a response at the normal latency, with arb_rdata = 64'hDEAD_BEEF_DEAD_BEEF. This preserves the engine's ack count.
- N consecutive read cycles produce N consecutive arb_valid cycles, in issue order. There are no gaps and no reordering.
- Mixed read/write streams: a write slot produces no response, which leaves a bubble in the arb_valid stream at that position.
- arb_rdata updates only when arb_valid=1 and holds its value otherwise.
- Statistics:
  - rd_cnt and wr_cnt increment per accepted request; out-of-range requests are included.
  - err_cnt and err_flag update on every address error.
  - All counters saturate at all-ones and never wrap.
- clr_stats=1: counters and err_flag go to 0 on the next edge. If clr_stats and an event fall in the same cycle, the clear wins and the event is not counted.
- clr_stats has no effect on the memory array or the response pipeline.

Optional Feature:
- Macro: ARB_MEM_RESPONDER_STATS_EN.
- Defined: rd_cnt, wr_cnt, err_cnt and err_flag behave as described above.
- Undefined: the counter and flag logic is not built. rd_cnt, wr_cnt, err_cnt and err_flag are tied to 0, and clr_stats is ignored.
- Decode, poison data and response timing are identical in both builds.

Test Plan:
- Reset check: assert rst asynchronously between edges → arb_valid=0, arb_rdata=0, err_flag=0, counters=0 immediately.
- Write/read latency (READ_LAT=4): write 64'h1122_3344_5566_7788 to 48'h40, then read 48'h40 in the next cycle → arb_valid high exactly 4 cycles after the read is accepted, arb_rdata=64'h1122_3344_5566_7788; wr_cnt=1, rd_cnt=1 (stats build).
- Burst: preload words 0..4095 with value = index; read a 4096-cycle back-to-back burst from BASE_ADDR → exactly 4096 consecutive arb_valid cycles with data 0..4095 in order; rd_cnt=4096.
- Address errors:
  - Read 48'h3 (misaligned) → poison 64'hDEAD_BEEF_DEAD_BEEF at normal latency.
  - Write to byte address 8 × 8192 → word 0 unchanged.
  - Result: err_cnt=2, err_flag=1. Then clr_stats in the same cycle as a third error → err_cnt=0, err_flag=0.
- Reset mid-burst: assert rst 2 cycles into a 10-read burst, release, idle 20 cycles → zero arb_valid pulses; memory still returns the preloaded data on a fresh read.
- Build without ARB_MEM_RESPONDER_STATS_EN: repeat the burst test → identical data/timing; rd_cnt, wr_cnt, err_cnt and err_flag stay 0.

Source files
------------

// File: rtl/arb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : arb_mem_responder
// Purpose  : Target-side 64-bit memory model for the engine arbiter port, with
//            a fixed-latency in-order read pipeline. Optional statistics are
//            enabled by defining ARB_MEM_RESPONDER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module arb_mem_responder #(
  parameter int          MEM_WORDS_LOG = 13,
  parameter logic [47:0] BASE_ADDR     = 48'h0,
  parameter int          READ_LAT      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arb_req,
  input  logic        arb_we,
  input  logic [47:0] arb_addr,
  input  logic [63:0] arb_wdata,
  output logic        arb_valid,
  output logic [63:0] arb_rdata,
  input  logic        clr_stats,
  output logic        err_flag,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt,
  output logic [15:0] err_cnt
);

  localparam int          C_WORDS  = 1 << MEM_WORDS_LOG;
  localparam logic [47:0] C_SPAN   = 48'(C_WORDS) << 3;
  localparam logic [63:0] C_POISON = 64'hDEAD_BEEF_DEAD_BEEF;

  logic                     w_borrow;
  logic [47:0]              w_off;
  logic [MEM_WORDS_LOG-1:0] w_idx;
  logic                     w_in_range;
  logic                     w_rd_acc;
  logic                     w_wr_acc;
  logic                     w_addr_err;
  logic [63:0]              w_rd_data;

  logic [63:0]              r_mem [C_WORDS];

  logic [READ_LAT-1:0]      w_vin;
  logic [63:0]              w_din [READ_LAT];
  logic [READ_LAT-1:0]      r_vld;
  logic [63:0]              r_dat [READ_LAT];

  // The borrow bit flags addresses below BASE_ADDR without a constant compare.
  always_comb begin
    {w_borrow, w_off} = {1'b0, arb_addr} - {1'b0, BASE_ADDR};
    w_idx      = w_off[MEM_WORDS_LOG+2:3];
    w_in_range = !w_borrow && (w_off < C_SPAN) && (arb_addr[2:0] == 3'd0);
    w_rd_acc   = arb_req && !arb_we;
    w_wr_acc   = arb_req && arb_we;
    w_addr_err = arb_req && !w_in_range;
    w_rd_data  = w_in_range ? r_mem[w_idx] : C_POISON;
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc && w_in_range) begin
      r_mem[w_idx] <= arb_wdata;
    end
  end

  always_comb begin
    w_vin    = '0;
    w_vin[0] = w_rd_acc;
    w_din[0] = w_rd_data;
    for (int i = 1; i < READ_LAT; i++) begin
      w_vin[i] = r_vld[i-1];
      w_din[i] = r_dat[i-1];
    end
  end

  // Data stages load only behind a valid, so the last stage holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld <= w_vin;
      for (int i = 0; i < READ_LAT; i++) begin
        if (w_vin[i]) begin
          r_dat[i] <= w_din[i];
        end
      end
    end
  end

  assign arb_valid = r_vld[READ_LAT-1];
  assign arb_rdata = r_dat[READ_LAT-1];

`ifdef ARB_MEM_RESPONDER_STATS_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_wr_cnt;
  logic [15:0] r_err_cnt;
  logic        r_err_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else if (clr_stats) begin
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_err_cnt  <= '0;
      r_err_flag <= 1'b0;
    end else begin
      if (w_rd_acc && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + 32'd1;
      end
      if (w_wr_acc && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + 32'd1;
      end
      if (w_addr_err) begin
        r_err_flag <= 1'b1;
        if (r_err_cnt != '1) begin
          r_err_cnt <= r_err_cnt + 16'd1;
        end
      end
    end
  end

  assign rd_cnt   = r_rd_cnt;
  assign wr_cnt   = r_wr_cnt;
  assign err_cnt  = r_err_cnt;
  assign err_flag = r_err_flag;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_stats;
  assign rd_cnt       = '0;
  assign wr_cnt       = '0;
  assign err_cnt      = '0;
  assign err_flag     = 1'b0;
`endif

endmodule
`default_nettype wire
